// File: rtl/fb_write_responder_if.sv
// fb_write_responder_if: draw-source write handshake between the draw units
// and the frame-buffer write responder.
// The master modport is the draw-source side and drives pixels.
// The slave modport is the responder side, which selects a source and
// signals when it is accepting pixels.

interface fb_write_responder_if #(
    parameter int SEL_W       = 2,
    parameter int COLOR_DEPTH = 9
);
    logic                   write_active;
    logic [COLOR_DEPTH-1:0] write_color_data;
    logic                   write_transparent;
    logic [31:0]            write_x_addr;
    logic [31:0]            write_y_addr;
    logic [SEL_W-1:0]       write_source_sel;
    logic                   write_awaited;

    modport master (
        output write_active,
        output write_color_data,
        output write_transparent,
        output write_x_addr,
        output write_y_addr,
        input  write_source_sel,
        input  write_awaited
    );

    modport slave (
        input  write_active,
        input  write_color_data,
        input  write_transparent,
        input  write_x_addr,
        input  write_y_addr,
        output write_source_sel,
        output write_awaited
    );
endinterface

// File: rtl/fb_write_responder.sv
// fb_write_responder: frame-buffer side of the draw-source write protocol.
// Once per frame it polls sources 0..MAX_WRITE_SOURCE in order.
// Opaque, in-bounds pixels are committed to the back bank of a double-buffered
// pixel RAM. The banks swap on the first frame pulse after every source has
// finished.
// Build option: define FB_WRITE_TIMEOUT_EN to add a per-source watchdog. The
// watchdog force-finishes a source after TIMEOUT_CYCLES service cycles and
// pulses timeout_pulse. Without it, timeout_pulse is tied low.

module fb_write_responder #(
    parameter int MAX_WRITE_SOURCE = 2,
    parameter int SEL_W            = 2,
    parameter int COLOR_DEPTH      = 9,
    parameter int WIDTH            = 640,
    parameter int HEIGHT           = 480,
    parameter int ADDR_W           = 19,
    parameter int SRC_START_CYCLES = 2,
    parameter int TIMEOUT_CYCLES   = 400000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame,
    fb_write_responder_if.slave        src,
    output logic                       fb_we,
    output logic [ADDR_W-1:0]          fb_waddr,
    output logic [COLOR_DEPTH-1:0]     fb_wdata,
    output logic                       fb_wbank,
    output logic                       front_bank,
    output logic                       draw_busy,
    output logic                       overrun,
    output logic                       timeout_pulse
);

    // A source needs at least one settle cycle, and its id must fit the select.
    if (SRC_START_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        MAX_WRITE_SOURCE >= (1 << SEL_W)) begin : g_bad_params
        $error("fb_write_responder: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        SERVICE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int                 SC_W     = $clog2(SRC_START_CYCLES + 1);
    localparam logic [SC_W-1:0]    SC_LAST  = SC_W'(SRC_START_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(MAX_WRITE_SOURCE);
    localparam logic [ADDR_W-1:0]  WIDTH_A  = ADDR_W'(WIDTH);
    localparam logic [31:0]        WIDTH_32 = 32'(WIDTH);
    localparam logic [31:0]        HEIGHT_32 = 32'(HEIGHT);

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SC_W-1:0]        scnt_q, scnt_d;
    logic                   front_q, front_d;
    logic                   wbank_q, wbank_d;
    logic                   overrun_q, overrun_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic [COLOR_DEPTH-1:0] wdata_q, wdata_d;

    logic                   accept;
    logic                   inBounds;
    logic                   srcDone;
    logic                   toutHit;
    logic [ADDR_W-1:0]      pixAddr;

    assign accept   = (state_q == SERVICE) & src.write_active;
    assign inBounds = (src.write_x_addr < WIDTH_32) && (src.write_y_addr < HEIGHT_32);
    assign pixAddr  = src.write_y_addr[ADDR_W-1:0] * WIDTH_A + src.write_x_addr[ADDR_W-1:0];
    assign srcDone  = ~src.write_active | toutHit;

`ifdef FB_WRITE_TIMEOUT_EN
    localparam int              TC_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TIMEOUT_CYCLES - 1);

    logic [TC_W-1:0] tcnt_q, tcnt_d;
    logic            tpulse_q, tpulse_d;

    // Watchdog counts service cycles of the current source and restarts outside SERVICE.
    always_comb begin
        tcnt_d   = '0;
        tpulse_d = 1'b0;
        toutHit  = (state_q == SERVICE) && (tcnt_q == TC_LAST);
        if (state_q == SERVICE && !toutHit) begin
            tcnt_d = tcnt_q + TC_W'(1);
        end
        if (toutHit && src.write_active) begin
            tpulse_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q   <= '0;
            tpulse_q <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            tpulse_q <= tpulse_d;
        end
    end

    assign timeout_pulse = tpulse_q;
`else
    assign toutHit       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    // Pass sequencing: poll each source in turn, then swap banks on the next frame.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        scnt_d    = scnt_q;
        front_d   = front_q;
        wbank_d   = wbank_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame) begin
                    sel_d   = '0;
                    scnt_d  = '0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                overrun_d = frame;
                if (scnt_q == SC_LAST) begin
                    state_d = SERVICE;
                end else begin
                    scnt_d = scnt_q + SC_W'(1);
                end
            end
            SERVICE: begin
                overrun_d = frame;
                if (srcDone) begin
                    if (sel_q == SEL_LAST) begin
                        state_d = DONE;
                    end else begin
                        sel_d   = sel_q + SEL_W'(1);
                        scnt_d  = '0;
                        state_d = SELECT;
                    end
                end
            end
            DONE: begin
                if (frame) begin
                    front_d = ~front_q;
                    wbank_d = ~wbank_q;
                    sel_d   = '0;
                    scnt_d  = '0;
                    state_d = SELECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit path: an accepted pixel reaches the RAM port one cycle later unless it is dropped.
    always_comb begin
        we_d    = accept & ~src.write_transparent & inBounds;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (we_d) begin
            waddr_d = pixAddr;
            wdata_d = src.write_color_data;
        end
    end

    // State, bank and commit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            scnt_q    <= '0;
            front_q   <= 1'b0;
            wbank_q   <= 1'b1;
            overrun_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            scnt_q    <= scnt_d;
            front_q   <= front_d;
            wbank_q   <= wbank_d;
            overrun_q <= overrun_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign src.write_source_sel = sel_q;
    assign src.write_awaited    = (state_q == SERVICE);
    assign draw_busy            = (state_q == SELECT) || (state_q == SERVICE);
    assign overrun              = overrun_q;
    assign front_bank           = front_q;
    assign fb_wbank             = wbank_q;
    assign fb_we                = we_q;
    assign fb_waddr             = waddr_q;
    assign fb_wdata             = wdata_q;

endmodule

// File: tb/tb_fb_write_responder.sv
// tb_fb_write_responder: directed bench for fb_write_responder.
// Expected RAM writes go into a scoreboard queue as pixels are driven.
// A negedge monitor pops each entry and compares address, data, latency and
// bank against the write the DUT produces.
// Build option: define FB_WRITE_TIMEOUT_EN to run the watchdog step, which
// uses TIMEOUT_CYCLES=8.

module tb_fb_write_responder;

    localparam int SEL_W       = 2;
    localparam int COLOR_DEPTH = 9;
    localparam int ADDR_W      = 19;
`ifdef FB_WRITE_TIMEOUT_EN
    localparam int TOUT = 8;
`else
    localparam int TOUT = 400000;
`endif

    typedef struct {
        logic [ADDR_W-1:0]      addr;
        logic [COLOR_DEPTH-1:0] data;
        int                     cyc;
    } expWrite_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   frame = 1'b0;
    logic                   fb_we;
    logic [ADDR_W-1:0]      fb_waddr;
    logic [COLOR_DEPTH-1:0] fb_wdata;
    logic                   fb_wbank;
    logic                   front_bank;
    logic                   draw_busy;
    logic                   overrun;
    logic                   timeout_pulse;

    expWrite_t              expQ[$];
    int                     assertCount = 0;
    int                     failCount = 0;
    int                     cyc = 0;
    int                     writeCount = 0;
    logic                   expWbank = 1'b1;
    logic [COLOR_DEPTH-1:0] mem650 = '0;

    fb_write_responder_if #(.SEL_W(SEL_W), .COLOR_DEPTH(COLOR_DEPTH)) bif ();

    fb_write_responder #(
        .MAX_WRITE_SOURCE (2),
        .SEL_W            (SEL_W),
        .COLOR_DEPTH      (COLOR_DEPTH),
        .WIDTH            (640),
        .HEIGHT           (480),
        .ADDR_W           (ADDR_W),
        .SRC_START_CYCLES (2),
        .TIMEOUT_CYCLES   (TOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame         (frame),
        .src           (bif),
        .fb_we         (fb_we),
        .fb_waddr      (fb_waddr),
        .fb_wdata      (fb_wdata),
        .fb_wbank      (fb_wbank),
        .front_bank    (front_bank),
        .draw_busy     (draw_busy),
        .overrun       (overrun),
        .timeout_pulse (timeout_pulse)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Posedge counter used to check the commit latency.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        expWrite_t e;
        if (!reset && fb_we === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'(fb_waddr), 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("waddr", 32'(fb_waddr), 32'(e.addr));
                checkOutput("wdata", 32'(fb_wdata), 32'(e.data));
                checkOutput("writeCycle", 32'(cyc), 32'(e.cyc));
                checkOutput("writeBank", 32'(fb_wbank), 32'(expWbank));
                writeCount++;
                if (fb_waddr == ADDR_W'(650)) mem650 = fb_wdata;
            end
        end
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: observed no finish, required finish");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic pulseFrame();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    // Drive one pixel for a single accept edge and record it if it should commit.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic [COLOR_DEPTH-1:0] c, input logic t);
        expWrite_t e;
        bif.write_active      = 1'b1;
        bif.write_x_addr      = x;
        bif.write_y_addr      = y;
        bif.write_color_data  = c;
        bif.write_transparent = t;
        if (!t && x < 32'd640 && y < 32'd480) begin
            e.addr = ADDR_W'(y * 32'd640 + x);
            e.data = c;
            e.cyc  = cyc + 1;
            expQ.push_back(e);
        end
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic finishSource();
        bif.write_active = 1'b0;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic waitAwaited(input logic [SEL_W-1:0] expSel);
        int n;
        n = 0;
        while (bif.write_awaited !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("awaitedSeen", 32'(bif.write_awaited), 32'd1);
        checkOutput("sourceSel", 32'(bif.write_source_sel), 32'(expSel));
    endtask

    initial begin
        bif.write_active      = 1'b0;
        bif.write_color_data  = '0;
        bif.write_transparent = 1'b0;
        bif.write_x_addr      = '0;
        bif.write_y_addr      = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        checkOutput("rstSel", 32'(bif.write_source_sel), 32'd0);
        checkOutput("rstAwaited", 32'(bif.write_awaited), 32'd0);
        checkOutput("rstWe", 32'(fb_we), 32'd0);
        checkOutput("rstWaddr", 32'(fb_waddr), 32'd0);
        checkOutput("rstWdata", 32'(fb_wdata), 32'd0);
        checkOutput("rstFront", 32'(front_bank), 32'd0);
        checkOutput("rstWbank", 32'(fb_wbank), 32'd1);
        checkOutput("rstBusy", 32'(draw_busy), 32'd0);
        checkOutput("rstOverrun", 32'(overrun), 32'd0);
        checkOutput("rstTimeout", 32'(timeout_pulse), 32'd0);

        // Pass 1: source 0 streams three pixels; sources 1 and 2 send nothing.
        pulseFrame();
        checkOutput("busyAfterFrame", 32'(draw_busy), 32'd1);
        checkOutput("noSwapFromIdle", 32'(front_bank), 32'd0);
        waitAwaited(2'd0);
        for (int i = 0; i < 3; i++) applyStimulus(32'(i), 32'd0, 9'h1FF, 1'b0);
        finishSource();
        waitAwaited(2'd1);
        finishSource();
        waitAwaited(2'd2);
        checkOutput("busyInService", 32'(draw_busy), 32'd1);
        finishSource();
        checkOutput("busyDone", 32'(draw_busy), 32'd0);
        checkOutput("awaitedDone", 32'(bif.write_awaited), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("pass1Pending", 32'(expQ.size()), 32'd0);
        checkOutput("pass1Writes", 32'(writeCount), 32'd3);

        // Pass 2: swap, bounds/transparency, overwrite order, overrun.
        pulseFrame();
        expWbank = 1'b0;
        checkOutput("swapFront", 32'(front_bank), 32'd1);
        checkOutput("swapWbank", 32'(fb_wbank), 32'd0);
        writeCount = 0;
        waitAwaited(2'd0);
        applyStimulus(32'd10, 32'd1, 9'h001, 1'b0);
        finishSource();
        waitAwaited(2'd1);
        applyStimulus(32'd639, 32'd479, 9'h1FF, 1'b0);
        applyStimulus(32'd640, 32'd0, 9'h055, 1'b0);
        applyStimulus(32'd5, 32'd5, 9'h077, 1'b1);
        applyStimulus(32'd0, 32'h0001_0000, 9'h033, 1'b0);
        finishSource();
        waitAwaited(2'd2);
        frame = 1'b1;
        applyStimulus(32'd10, 32'd1, 9'h1C0, 1'b0);
        checkOutput("overrunPulse", 32'(overrun), 32'd1);
        checkOutput("overrunNoSwap", 32'(front_bank), 32'd1);
        finishSource();
        checkOutput("overrunOneCycle", 32'(overrun), 32'd0);
        checkOutput("busyDone2", 32'(draw_busy), 32'd0);
        checkOutput("frontHeld", 32'(front_bank), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("pass2Pending", 32'(expQ.size()), 32'd0);
        checkOutput("pass2Writes", 32'(writeCount), 32'd3);
        checkOutput("lastWrite650", 32'(mem650), 32'h1C0);

        // Pass 3: frame in DONE swaps back.
        pulseFrame();
        expWbank = 1'b1;
        checkOutput("swapBackFront", 32'(front_bank), 32'd0);
        checkOutput("swapBackWbank", 32'(fb_wbank), 32'd1);
        checkOutput("noOverrunInDone", 32'(overrun), 32'd0);
        for (int s = 0; s < 3; s++) begin
            waitAwaited(SEL_W'(s));
            finishSource();
        end

        // Pass 4: reset mid-SERVICE with sel=1 and front_bank=1.
        pulseFrame();
        expWbank = 1'b0;
        checkOutput("pass4Front", 32'(front_bank), 32'd1);
        waitAwaited(2'd0);
        finishSource();
        waitAwaited(2'd1);
        reset = 1'b1;
        #1;
        checkOutput("asyncRstSel", 32'(bif.write_source_sel), 32'd0);
        checkOutput("asyncRstAwaited", 32'(bif.write_awaited), 32'd0);
        checkOutput("asyncRstFront", 32'(front_bank), 32'd0);
        checkOutput("asyncRstWbank", 32'(fb_wbank), 32'd1);
        @(negedge clk);
        checkOutput("rstBusy2", 32'(draw_busy), 32'd0);
        checkOutput("rstWe2", 32'(fb_we), 32'd0);
        checkOutput("rstFront2", 32'(front_bank), 32'd0);
        reset = 1'b0;
        expWbank = 1'b1;

        // Pass 5: frame coincides with the final finish.
        pulseFrame();
        checkOutput("pass5NoSwap", 32'(front_bank), 32'd0);
        waitAwaited(2'd0);
        finishSource();
        waitAwaited(2'd1);
        finishSource();
        waitAwaited(2'd2);
        frame = 1'b1;
        finishSource();
        checkOutput("finishOverrun", 32'(overrun), 32'd1);
        checkOutput("finishBusy", 32'(draw_busy), 32'd0);
        checkOutput("finishNoSwap", 32'(front_bank), 32'd0);
        pulseFrame();
        expWbank = 1'b0;
        checkOutput("laterSwapFront", 32'(front_bank), 32'd1);
        checkOutput("laterSwapWbank", 32'(fb_wbank), 32'd0);

`ifdef FB_WRITE_TIMEOUT_EN
        // Watchdog: source 0 never drops write_active.
        waitAwaited(2'd0);
        for (int i = 0; i < 7; i++) applyStimulus(32'd0, 32'd0, 9'h000, 1'b1);
        checkOutput("noEarlyTimeout", 32'(timeout_pulse), 32'd0);
        applyStimulus(32'd0, 32'd0, 9'h000, 1'b1);
        checkOutput("timeoutPulse", 32'(timeout_pulse), 32'd1);
        checkOutput("timeoutSel", 32'(bif.write_source_sel), 32'd1);
        bif.write_active = 1'b0;
        @(negedge clk);
        checkOutput("timeoutOneCycle", 32'(timeout_pulse), 32'd0);
        waitAwaited(2'd1);
        finishSource();
        waitAwaited(2'd2);
        finishSource();
`else
        for (int s = 0; s < 3; s++) begin
            waitAwaited(SEL_W'(s));
            finishSource();
        end
        checkOutput("timeoutTiedLow", 32'(timeout_pulse), 32'd0);
`endif
        repeat (2) @(negedge clk);
        checkOutput("finalPending", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/fb_write_responder.md
Name: fb_write_responder

Overview:
- Responder (frame-buffer side) of the draw-source write protocol: per frame, polls sources 0..MAX_WRITE_SOURCE in order through write_source_sel/write_awaited.
- Accepts each source's pixel stream and commits non-transparent, in-bounds pixels to the back bank of a double-buffered pixel RAM.
- Swaps banks on the first frame pulse after all sources finish.
- Sits between the draw units (background, starfield, g-sensor overlay) and the dual-bank pixel RAM that the display reader scans.

Parameters:
- MAX_WRITE_SOURCE, 2, highest source id serviced (ids 0..MAX_WRITE_SOURCE)
- SEL_W, 2, width of write_source_sel; must hold MAX_WRITE_SOURCE
- COLOR_DEPTH, 9, pixel colour width
- WIDTH, 640, visible columns
- HEIGHT, 480, visible rows
- ADDR_W, 19, RAM address width; must hold WIDTH*HEIGHT-1
- SRC_START_CYCLES, 2, cycles after a select change before write_active is sampled
- TIMEOUT_CYCLES, 400000, per-source watchdog limit (optional feature only)

Ports:
- clk  in  1  pixel-domain clock (25 MHz)
- reset  in  1  asynchronous, active-high reset
- frame  in  1  one-cycle start-of-frame pulse
- write_active  in  1  selected source has a valid pixel this cycle
- write_color_data  in  COLOR_DEPTH  pixel colour
- write_transparent  in  1  pixel is transparent; drop it
- write_x_addr  in  32  pixel column
- write_y_addr  in  32  pixel row
- write_source_sel  out  SEL_W  source id currently serviced
- write_awaited  out  1  responder accepting pixels from the selected source
- fb_we  out  1  RAM write enable
- fb_waddr  out  ADDR_W  linear address, y*WIDTH+x
- fb_wdata  out  COLOR_DEPTH  RAM write data
- fb_wbank  out  1  bank being written (back bank, = ~front_bank)
- front_bank  out  1  bank the display reader scans
- draw_busy  out  1  high from frame accept until all sources finish
- overrun  out  1  one-cycle pulse when frame arrives while draw_busy
- timeout_pulse  out  1  one-cycle pulse when the watchdog fires (optional feature)

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, write_source_sel=0, write_awaited=0, fb_we=0, fb_waddr=0, fb_wdata=0.
  - front_bank=0, fb_wbank=1, draw_busy=0, overrun=0, timeout_pulse=0, swap_pending=0.
- FSM states:
  - IDLE: wait for frame. On frame: draw_busy<=1, sel<=0, go to SELECT.
  - SELECT: write_awaited=0. Count SRC_START_CYCLES cycles, then go to SERVICE.
  - SERVICE: write_awaited=1.
    - write_active=1: accept one pixel per cycle.
    - write_active=0 for one cycle: source finished (zero pixels is legal). If sel==MAX_WRITE_SOURCE go to DONE; else sel<=sel+1 and go to SELECT.
  - DONE: draw_busy=0, write_awaited=0. Wait for frame.
    - On frame: front_bank<=~front_bank and fb_wbank<=~fb_wbank in the same cycle.
    - Then, in the same cycle, start the next pass as from IDLE (draw_busy<=1, sel<=0, enter SELECT).
- Accept and commit:
  - Accept means write_active & write_awaited.
  - Registered commit one cycle after accept: fb_we=1, fb_waddr=y*WIDTH+x (ADDR_W bits), fb_wdata=colour.
  - Commit happens only if write_transparent=0, x<WIDTH and y<HEIGHT (full 32-bit compare, no wrap). Otherwise fb_we=0 and the pixel is silently dropped.
- Source order: higher id commits later, so it overwrites lower ids at the same address.
- Frame while draw_busy (SELECT/SERVICE):
  - overrun pulses for one cycle; drawing continues; no swap.
  - The swap waits for the next frame in DONE; the old front is shown again.
- fb_wbank changes only on a swap, never mid-pass.
- Frame in the same cycle as the final finish: treated as overrun. The FSM enters DONE and the swap waits for the following frame.

Optional Feature:
- Macro: FB_WRITE_TIMEOUT_EN.
- Enabled:
  - A counter resets on entry to SERVICE and increments each SERVICE cycle.
  - On reaching TIMEOUT_CYCLES: force finish of the current source (same transitions as write_active=0) and pulse timeout_pulse for 1 cycle.
- Disabled: no counter; timeout_pulse tied to 0; a source that never drops write_active stalls the pass.

Test Plan:
- Reset mid-SERVICE, sel=1, front_bank=1 -> next cycle: all outputs at reset values, front_bank=0, fb_wbank=1.
- Frame; source 0 streams 3 pixels (x=0..2, y=0, colour 0x1FF), then drops write_active; sources 1,2 send none -> fb_we high for 3 cycles, each one cycle after its accept; addrs 0,1,2; fb_wbank=1; draw_busy falls on DONE entry.
- Source 1 pixels: x=639,y=479 (opaque); x=640,y=0; x=5,y=5 with transparent=1 -> exactly one write, addr 307199.
- Sources 0 and 2 both write x=10,y=1 with colours 0x001 and 0x1C0 -> last write to addr 650 is 0x1C0.
- Frame during SERVICE of source 2 -> overrun=1 for 1 cycle, front_bank unchanged; next frame in DONE -> front_bank toggles.
- With FB_WRITE_TIMEOUT_EN and TIMEOUT_CYCLES=8, source 0 holds write_active=1 -> after 8 SERVICE cycles: timeout_pulse=1, sel goes to 1.
